// File: rtl/rtc_bus_arbiter.sv
// Bus sequencer and two-way arbiter for the external RTC multiplexed AD bus.
// Ports: clk/reset; req_rd/addr_rd and req_wr/addr_wr/wdata requesters;
//   gnt_*/done_* handshake; rdata/rdata_valid read return;
//   bus_out/bus_in/bus_oe AD bus; cs_n/rd_n/wr_n/ad_n strobes.
module rtc_bus_arbiter #(
    parameter int unsigned T_PHASE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_rd,
    input  logic [7:0] addr_rd,
    input  logic       req_wr,
    input  logic [7:0] addr_wr,
    input  logic [7:0] wdata,
    output logic       gnt_rd,
    output logic       gnt_wr,
    output logic       done_rd,
    output logic       done_wr,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic [7:0] bus_out,
    input  logic [7:0] bus_in,
    output logic       bus_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_n
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        AHOLD,
        DATA,
        DHOLD,
        DONE
    } state_t;

    localparam logic [7:0] RELOAD = 8'(T_PHASE - 1);

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic       phase_end;
    logic       last_wr, last_wr_nx;
    logic       own_wr, own_wr_nx;
    logic [7:0] addr_q, addr_nx;
    logic [7:0] wdata_q, wdata_nx;
    logic [7:0] samp_q, samp_nx;

    logic       gnt_rd_nx, gnt_wr_nx;
    logic       done_rd_nx, done_wr_nx;
    logic [7:0] rdata_nx;
    logic       rdata_valid_nx;
    logic [7:0] bus_out_nx;
    logic       bus_oe_nx;
    logic       cs_n_nx, rd_n_nx, wr_n_nx, ad_n_nx;

    always_comb begin
        state_nx   = state;
        own_wr_nx  = own_wr;
        last_wr_nx = last_wr;
        addr_nx    = addr_q;
        wdata_nx   = wdata_q;
        samp_nx    = samp_q;
        phase_end  = (cnt == 8'd0);

        unique case (state)
            IDLE: begin
                if (req_rd || req_wr) begin
                    // On a tie, the requester not served last time wins.
                    own_wr_nx = (req_rd && req_wr) ? ~last_wr : req_wr;
                    addr_nx   = own_wr_nx ? addr_wr : addr_rd;
                    wdata_nx  = wdata;
                    state_nx  = ADDR;
                end
            end
            ADDR:  if (phase_end) state_nx = AHOLD;
            AHOLD: if (phase_end) state_nx = DATA;
            DATA: begin
                if (phase_end) begin
                    // Last DATA cycle: rd_n is still low here.
                    samp_nx  = bus_in;
                    state_nx = DHOLD;
                end
            end
            DHOLD: if (phase_end) state_nx = DONE;
            DONE: begin
                last_wr_nx = own_wr;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (state_nx != state) begin
            cnt_nx = RELOAD;
        end else if (phase_end) begin
            cnt_nx = cnt;
        end else begin
            cnt_nx = cnt - 8'd1;
        end

        // Outputs are decoded from the next state so they register
        // in step with the state itself.
        cs_n_nx    = 1'b1;
        rd_n_nx    = 1'b1;
        wr_n_nx    = 1'b1;
        ad_n_nx    = 1'b1;
        bus_oe_nx  = 1'b0;
        bus_out_nx = bus_out;
        rdata_nx   = rdata;

        unique case (state_nx)
            ADDR: begin
                cs_n_nx    = 1'b0;
                ad_n_nx    = 1'b0;
                wr_n_nx    = 1'b0;
                bus_oe_nx  = 1'b1;
                bus_out_nx = addr_nx;
            end
            AHOLD: begin
                bus_oe_nx  = 1'b1;
                bus_out_nx = addr_nx;
            end
            DATA: begin
                cs_n_nx = 1'b0;
                if (own_wr_nx) begin
                    wr_n_nx    = 1'b0;
                    bus_oe_nx  = 1'b1;
                    bus_out_nx = wdata_nx;
                end else begin
                    rd_n_nx = 1'b0;
                end
            end
            DONE: if (!own_wr_nx) rdata_nx = samp_q;
            default: ;
        endcase

        gnt_rd_nx      = (state_nx != IDLE) && !own_wr_nx;
        gnt_wr_nx      = (state_nx != IDLE) && own_wr_nx;
        done_rd_nx     = (state_nx == DONE) && !own_wr_nx;
        done_wr_nx     = (state_nx == DONE) && own_wr_nx;
        rdata_valid_nx = done_rd_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            last_wr     <= 1'b1;
            own_wr      <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            samp_q      <= 8'h00;
            gnt_rd      <= 1'b0;
            gnt_wr      <= 1'b0;
            done_rd     <= 1'b0;
            done_wr     <= 1'b0;
            rdata       <= 8'h00;
            rdata_valid <= 1'b0;
            bus_out     <= 8'h00;
            bus_oe      <= 1'b0;
            cs_n        <= 1'b1;
            rd_n        <= 1'b1;
            wr_n        <= 1'b1;
            ad_n        <= 1'b1;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            last_wr     <= last_wr_nx;
            own_wr      <= own_wr_nx;
            addr_q      <= addr_nx;
            wdata_q     <= wdata_nx;
            samp_q      <= samp_nx;
            gnt_rd      <= gnt_rd_nx;
            gnt_wr      <= gnt_wr_nx;
            done_rd     <= done_rd_nx;
            done_wr     <= done_wr_nx;
            rdata       <= rdata_nx;
            rdata_valid <= rdata_valid_nx;
            bus_out     <= bus_out_nx;
            bus_oe      <= bus_oe_nx;
            cs_n        <= cs_n_nx;
            rd_n        <= rd_n_nx;
            wr_n        <= wr_n_nx;
            ad_n        <= ad_n_nx;
        end
    end

endmodule

// File: doc/rtc_bus_arbiter.md
Name: rtc_bus_arbiter

Overview:
- Sequences the multiplexed address/data bus of the external RTC chip and shares it between two requesters: the read engine (time/date readout) and the write engine (user time-set).
- Generates cs_n, rd_n, wr_n and ad_n with programmable phase widths.
- Latches the winning requester's address and data, and returns read data with a valid pulse.
- Registered control outputs are combined downstream with the board-level OR/enable gating.

Parameters:
T_PHASE, 4, clock cycles per bus phase (1..255); sets strobe width and hold time.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_rd  in  1  read engine request; held high until done_rd
addr_rd  in  8  RTC register address for read
req_wr  in  1  write engine request; held high until done_wr
addr_wr  in  8  RTC register address for write
wdata  in  8  data to write
gnt_rd  out  1  read engine owns the bus (whole transaction)
gnt_wr  out  1  write engine owns the bus (whole transaction)
done_rd  out  1  one-cycle pulse, read transaction complete
done_wr  out  1  one-cycle pulse, write transaction complete
rdata  out  8  data captured from RTC
rdata_valid  out  1  one-cycle pulse, coincident with done_rd
bus_out  out  8  value driven onto AD bus
bus_in  in  8  value sampled from AD bus
bus_oe  out  1  1 = FPGA drives AD bus
cs_n  out  1  chip select, active low
rd_n  out  1  read strobe, active low
wr_n  out  1  write strobe, active low
ad_n  out  1  0 = address phase, 1 = data phase

Behaviour:
- Clock and reset: single clock domain (clk), synchronous active-high reset. All outputs are registered.
- Reset values: gnt_rd=gnt_wr=0, done_*=0, rdata=0x00, rdata_valid=0, bus_out=0x00, bus_oe=0, cs_n=rd_n=wr_n=ad_n=1, state=IDLE, last_served=WR (so read wins the first tie).
- States and outputs:
  - IDLE: all strobes high, bus_oe=0.
  - ADDR: cs_n=0, ad_n=0, wr_n=0, bus_oe=1, bus_out=latched address.
  - AHOLD: strobes high, bus_oe=1, address held.
  - DATA: cs_n=0, ad_n=1. Write: wr_n=0, bus_oe=1, bus_out=latched wdata. Read: rd_n=0, bus_oe=0.
  - DHOLD: strobes high, bus_oe=0.
  - DONE: one cycle; done_x=1 for the owner; gnt deasserts on exit.
- Phase length: ADDR, AHOLD, DATA and DHOLD each last exactly T_PHASE cycles, counted by an 8-bit down-counter reloaded on every state entry.
- Arbitration, evaluated in IDLE only:
  - One request high: grant it.
  - Both high: grant the one that is not last_served (round-robin).
  - last_served updates on DONE.
  - Requests are ignored outside IDLE.
- Request latching: address and wdata are latched on the edge that leaves IDLE. Later changes to the inputs, or a request dropping mid-transaction, have no effect; the transaction completes.
- Read sampling: bus_in is sampled on the final cycle of DATA, while rd_n is still low. rdata updates at DONE entry, and rdata_valid pulses with done_rd. rdata holds its value otherwise.
- Latency: with the request sampled at edge k, ADDR occupies cycles k+1..k+T, and DONE falls at cycle k+4T+1. With T_PHASE=4, done is at k+17.
- Back-to-back: DONE returns to IDLE; IDLE must last at least 1 cycle before the next grant, giving a minimum bus turnaround of 1 cycle with all strobes high.
- Strobe exclusivity: rd_n and wr_n are never low simultaneously. bus_oe is never 1 while rd_n=0.
- Reset mid-transaction: on the next edge everything goes to reset values, no done pulse is issued, and last_served returns to WR.

Test Plan:
- Single write: req_wr=1, addr_wr=0x21, wdata=0x45, T_PHASE=4.
  - ADDR: bus_out=0x21, ad_n=0, wr_n=0 for 4 cycles.
  - DATA: bus_out=0x45, ad_n=1, wr_n=0 for 4 cycles.
  - done_wr pulses at k+17; rd_n stays 1 throughout.
- Single read: req_rd=1, addr_rd=0x22, bus_in=0x59 during DATA.
  - rd_n=0 for 4 cycles with bus_oe=0.
  - rdata=0x59 and rdata_valid=1 on the same cycle as done_rd, at k+17.
- Simultaneous after reset: both requests held high.
  - Sequence: read first, then write, then read, alternating gnt_rd/gnt_wr.
  - Never two consecutive grants to the same requester.
- Input change mid-transaction: change addr_wr and wdata and drop req_wr during AHOLD.
  - The bus still shows the originally latched values.
  - done_wr still pulses.
- Reset in DATA of a write: assert reset for 1 cycle.
  - Next cycle: all strobes=1, bus_oe=0, gnt=0, no done_wr.
  - With both requests high afterwards, read wins.
- T_PHASE=1: single read.
  - Each phase lasts 1 cycle; done_rd at k+5.
  - No cycle with rd_n and wr_n both low.
